bist_controller: RTL and testbench

- Sequences a built-in self-test run around the team's LFSR pattern generator.
- Seeds and steps the LFSR for a programmed number of patterns and drives each pattern to the circuit under test (CUT).
- Compacts CUT responses into an internal MISR signature, then compares it with a golden signature and reports done/pass.
- Sits between the BIST top level (start, seed, golden value) and the LFSR/CUT datapath.

---
 rtl/bist_controller.sv | 219 +++++++++++++++++++++
 tb/tb_bist_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bist_controller.sv
// bist_controller
//   Sequences one BIST run: seeds the external LFSR, steps it for a
//   programmed number of patterns, and drives each pattern to the CUT.
//   CUT responses are compacted into a MISR, and the final signature is
//   compared with a golden value.
//
//   Optional feature, enabled by defining BIST_ABORT_EN:
//     adds the bist_abort input and the bist_aborted output. An abort
//     during a run returns the block to IDLE without reporting a result.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for bist_start; nothing driven
//   SEED    | lfsr_load strobe; clear MISR, pattern counter, valid pipe
//   RUN     | lfsr_en high; pattern to CUT; push 1 into the valid pipe
//   DRAIN   | CUT_LAT cycles pushing 0 so the last responses reach MISR
//   COMPARE | register pass = (signature == golden)
//   DONE    | bist_done high; result held until next start or reset

module bist_controller #(
    parameter int                     NUM_BITS  = 4,
    parameter int                     SIG_BITS  = 8,
    parameter int                     CNT_W     = 8,
    parameter int                     CUT_LAT   = 1,
    parameter logic [SIG_BITS-1:0]    MISR_POLY = 8'h1D
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  bist_start,
    input  logic [NUM_BITS-1:0]   seed,
    input  logic [CNT_W-1:0]      num_patterns,
    input  logic [SIG_BITS-1:0]   golden_sig,
`ifdef BIST_ABORT_EN
    input  logic                  bist_abort,
    output logic                  bist_aborted,
`endif
    output logic                  lfsr_load,
    output logic                  lfsr_en,
    output logic [NUM_BITS-1:0]   lfsr_seed,
    input  logic [NUM_BITS-1:0]   lfsr_out,
    output logic [NUM_BITS-1:0]   cut_pattern,
    input  logic [SIG_BITS-1:0]   cut_response,
    output logic [SIG_BITS-1:0]   misr_sig,
    output logic                  bist_busy,
    output logic                  bist_done,
    output logic                  bist_pass
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEED    = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // DRAIN length is held in a small down-counter; CUT_LAT is at most 4.
    localparam logic [2:0] DRAIN_LOAD = 3'(CUT_LAT - 1);

    state_t                 state_q,  state_d;
    logic [NUM_BITS-1:0]    seed_q,   seed_d;
    logic [CNT_W-1:0]       count_q,  count_d;
    logic [SIG_BITS-1:0]    golden_q, golden_d;
    logic [SIG_BITS-1:0]    misr_q,   misr_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [2:0]             drain_q,  drain_d;
    logic [CUT_LAT-1:0]     vpipe_q,  vpipe_d;
    logic                   pass_q,   pass_d;
`ifdef BIST_ABORT_EN
    logic                   aborted_q, aborted_d;
`endif

    logic                   push_valid;
    logic                   clear_pipe;
    logic                   resp_valid;
    logic                   busy;
    logic [SIG_BITS-1:0]    misr_next;

    assign resp_valid = vpipe_q[CUT_LAT-1];
    assign busy       = (state_q == S_SEED) || (state_q == S_RUN) ||
                        (state_q == S_DRAIN) || (state_q == S_COMPARE);

    // Galois-style MISR step: shift, fold in taps on MSB, xor in response.
    assign misr_next = {misr_q[SIG_BITS-2:0], 1'b0}
                     ^ (misr_q[SIG_BITS-1] ? MISR_POLY : '0)
                     ^ cut_response;

    // State and datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            seed_q    <= '0;
            count_q   <= '0;
            golden_q  <= '0;
            misr_q    <= '0;
            cnt_q     <= '0;
            drain_q   <= '0;
            vpipe_q   <= '0;
            pass_q    <= 1'b0;
`ifdef BIST_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            seed_q    <= seed_d;
            count_q   <= count_d;
            golden_q  <= golden_d;
            misr_q    <= misr_d;
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            vpipe_q   <= vpipe_d;
            pass_q    <= pass_d;
`ifdef BIST_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    // Next-state, latching and MISR update.
    always_comb begin
        state_d    = state_q;
        seed_d     = seed_q;
        count_d    = count_q;
        golden_d   = golden_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        pass_d     = pass_q;
        misr_d     = misr_q;
        push_valid = 1'b0;
        clear_pipe = 1'b0;
`ifdef BIST_ABORT_EN
        aborted_d  = aborted_q;
`endif

        if (resp_valid) begin
            misr_d = misr_next;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bist_start) begin
                    seed_d   = seed;
                    count_d  = num_patterns;
                    golden_d = golden_sig;
                    pass_d   = 1'b0;
`ifdef BIST_ABORT_EN
                    aborted_d = 1'b0;
`endif
                    state_d  = S_SEED;
                end
            end
            S_SEED: begin
                misr_d     = '0;
                cnt_d      = '0;
                clear_pipe = 1'b1;
                drain_d    = DRAIN_LOAD;
                // An empty run still passes through DRAIN so the start-to-done
                // latency is N + CUT_LAT + 2 for every N, including zero.
                state_d    = (count_q != '0) ? S_RUN : S_DRAIN;
            end
            S_RUN: begin
                push_valid = 1'b1;
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == count_q - CNT_W'(1)) begin
                    drain_d = DRAIN_LOAD;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_q == 3'd0) begin
                    state_d = S_COMPARE;
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            S_COMPARE: begin
                pass_d  = (misr_q == golden_q);
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef BIST_ABORT_EN
        if (bist_abort && busy) begin
            state_d    = S_IDLE;
            pass_d     = 1'b0;
            aborted_d  = 1'b1;
            clear_pipe = 1'b1;
        end
`endif
    end

    // Valid pipe: marks the cycle each applied pattern's response is usable.
    always_comb begin
        vpipe_d = '0;
        if (!clear_pipe) begin
            vpipe_d[0] = push_valid;
            for (int i = 1; i < CUT_LAT; i++) begin
                vpipe_d[i] = vpipe_q[i-1];
            end
        end
    end

    assign lfsr_load   = (state_q == S_SEED);
    assign lfsr_en     = (state_q == S_RUN);
    assign lfsr_seed   = seed_q;
    assign cut_pattern = (state_q == S_RUN) ? lfsr_out : '0;
    assign misr_sig    = misr_q;
    assign bist_busy   = busy;
    assign bist_done   = (state_q == S_DONE);
    assign bist_pass   = pass_q;
`ifdef BIST_ABORT_EN
    assign bist_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: table of complete runs plus hand-written
// sequences for start-while-busy, mid-run reset and (if BIST_ABORT_EN) abort.
module tb_bist_controller;

    localparam int NB  = 4;
    localparam int SB  = 8;
    localparam int CW  = 8;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          bist_start;
    logic [NB-1:0] seed;
    logic [CW-1:0] num_patterns;
    logic [SB-1:0] golden_sig;
    logic          lfsr_load;
    logic          lfsr_en;
    logic [NB-1:0] lfsr_seed;
    logic [NB-1:0] lfsr_out;
    logic [NB-1:0] cut_pattern;
    logic [SB-1:0] cut_response;
    logic [SB-1:0] misr_sig;
    logic          bist_busy;
    logic          bist_done;
    logic          bist_pass;
`ifdef BIST_ABORT_EN
    logic          bist_abort;
    logic          bist_aborted;
`endif

    int n_pass  = 0;
    int n_total = 0;

    bist_controller #(
        .NUM_BITS (NB),
        .SIG_BITS (SB),
        .CNT_W    (CW),
        .CUT_LAT  (LAT),
        .MISR_POLY(8'h1D)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .bist_start  (bist_start),
        .seed        (seed),
        .num_patterns(num_patterns),
        .golden_sig  (golden_sig),
`ifdef BIST_ABORT_EN
        .bist_abort  (bist_abort),
        .bist_aborted(bist_aborted),
`endif
        .lfsr_load   (lfsr_load),
        .lfsr_en     (lfsr_en),
        .lfsr_seed   (lfsr_seed),
        .lfsr_out    (lfsr_out),
        .cut_pattern (cut_pattern),
        .cut_response(cut_response),
        .misr_sig    (misr_sig),
        .bist_busy   (bist_busy),
        .bist_done   (bist_done),
        .bist_pass   (bist_pass)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] seed;
        logic [CW-1:0] n;
        logic [SB-1:0] golden;
        logic [SB-1:0] resp;
        logic [SB-1:0] exp_misr;
        logic          exp_pass;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] all_outs();
        return {11'd0, lfsr_load, lfsr_en, lfsr_seed, cut_pattern, misr_sig,
                bist_busy, bist_done, bist_pass};
    endfunction

    // Runs one vector from start to done; glitch_j >= 0 pulses a conflicting
    // start (with different inputs) in cycle glitch_j after the accepted start.
    task automatic run_vec(input string tag, input vec_t v, input int glitch_j);
        int  j;
        int  seq_err;
        bit  done_seen;
        logic [SB-1:0] misr_at_done;
        logic          exp_en;
        @(negedge clk);
        seed         = v.seed;
        num_patterns = v.n;
        golden_sig   = v.golden;
        cut_response = v.resp;
        bist_start   = 1'b1;
        @(posedge clk);
        j = 0;
        seq_err = 0;
        done_seen = 1'b0;
        while (j < 400) begin
            @(negedge clk);
            if (j == 0) bist_start = 1'b0;
            if (bist_done) begin
                done_seen = 1'b1;
                break;
            end
            exp_en = (j >= 1) && (j <= int'(v.n));
            if (lfsr_load !== (j == 0)) seq_err++;
            if (lfsr_en !== exp_en) seq_err++;
            if (cut_pattern !== (exp_en ? lfsr_out : 4'h0)) seq_err++;
            if (lfsr_seed !== v.seed) seq_err++;
            if (bist_busy !== 1'b1) seq_err++;
            if (bist_pass !== 1'b0) seq_err++;
`ifdef BIST_ABORT_EN
            if (bist_aborted !== 1'b0) seq_err++;
`endif
            if (glitch_j >= 0 && j == glitch_j) begin
                bist_start   = 1'b1;
                seed         = ~v.seed;
                num_patterns = 8'd1;
                golden_sig   = ~v.golden;
            end else if (glitch_j >= 0 && j == glitch_j + 1) begin
                bist_start   = 1'b0;
                seed         = v.seed;
                num_patterns = v.n;
                golden_sig   = v.golden;
            end
            lfsr_out = lfsr_out + 4'd3;
            @(posedge clk);
            j++;
        end
        check({tag, "_cycles"}, 32'(seq_err), 32'd0);
        if (!done_seen) begin
            check({tag, "_done_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_latency"}, 32'(j), 32'(int'(v.n) + LAT + 2));
            check({tag, "_misr"}, 32'(misr_sig), 32'(v.exp_misr));
            check({tag, "_pass"}, 32'(bist_pass), 32'(v.exp_pass));
            check({tag, "_done_outs"}, {28'd0, bist_busy, lfsr_en, lfsr_load, |cut_pattern}, 32'd0);
            misr_at_done = misr_sig;
            repeat (3) @(negedge clk);
            check({tag, "_hold"}, {22'd0, bist_done, bist_pass, misr_sig},
                  {22'd0, 1'b1, v.exp_pass, misr_at_done});
        end
    endtask

    initial begin
        vecs[0] = '{4'h1, 8'd3,   8'h00, 8'h00, 8'h00, 1'b1};
        vecs[1] = '{4'h2, 8'd2,   8'h03, 8'h01, 8'h03, 1'b1};
        vecs[2] = '{4'h3, 8'd2,   8'h04, 8'h01, 8'h03, 1'b0};
        vecs[3] = '{4'h4, 8'd0,   8'h00, 8'h01, 8'h00, 1'b1};
        vecs[4] = '{4'h9, 8'd0,   8'h5A, 8'h00, 8'h00, 1'b0};
        vecs[5] = '{4'h6, 8'd5,   8'h24, 8'h81, 8'h24, 1'b1};
        vecs[6] = '{4'hB, 8'd1,   8'hA5, 8'hA5, 8'hA5, 1'b1};
        vecs[7] = '{4'hC, 8'd2,   8'h9D, 8'h80, 8'h9D, 1'b1};
        vecs[8] = '{4'hF, 8'd255, 8'h00, 8'h00, 8'h00, 1'b1};

        n_rst        = 1'b0;
        bist_start   = 1'b0;
        seed         = '0;
        num_patterns = '0;
        golden_sig   = '0;
        lfsr_out     = 4'h5;
        cut_response = '0;
`ifdef BIST_ABORT_EN
        bist_abort   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", all_outs(), 32'd0);
`ifdef BIST_ABORT_EN
        check("reset_aborted", 32'(bist_aborted), 32'd0);
`endif
        n_rst = 1'b1;
        @(negedge clk);
        check("idle_outs", all_outs(), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i], -1);
        end

        // start pulsed mid-RUN with different inputs must be ignored
        run_vec("ignore_start", '{4'h5, 8'd4, 8'h0F, 8'h01, 8'h0F, 1'b1}, 2);

        // reset in the 2nd RUN cycle, then a full run
        @(negedge clk);
        seed = 4'h7; num_patterns = 8'd4; golden_sig = 8'h0F; cut_response = 8'h01;
        bist_start = 1'b1;
        @(posedge clk);
        @(negedge clk); bist_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("prereset_run", {30'd0, lfsr_en, bist_busy}, 32'd3);
        n_rst = 1'b0;
        #1;
        check("midrun_reset_outs", all_outs(), 32'd0);
        @(negedge clk);
        check("reset_held_outs", all_outs(), 32'd0);
        n_rst = 1'b1;
        run_vec("after_reset", '{4'h7, 8'd4, 8'h0F, 8'h01, 8'h0F, 1'b1}, -1);

`ifdef BIST_ABORT_EN
        @(negedge clk);
        seed = 4'h8; num_patterns = 8'd5; golden_sig = 8'h00; cut_response = 8'h00;
        bist_start = 1'b1;
        @(posedge clk);
        @(negedge clk); bist_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        bist_abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bist_abort = 1'b0;
        check("abort_state", {27'd0, bist_busy, lfsr_en, bist_done, bist_pass, bist_aborted}, 32'd1);
        bist_abort = 1'b1;
        @(negedge clk);
        bist_abort = 1'b0;
        @(negedge clk);
        check("abort_idle_ignored", {29'd0, bist_busy, bist_done, bist_aborted}, 32'd1);
        run_vec("after_abort", vecs[1], -1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
